// File: rtl/warp_context_table.sv
// rtl/warp_context_table.sv - per-core warp context store: PC, mask, status, age
// with barrier release and registered occupancy summaries.
module warp_context_table #(
    parameter int NUM_WARPS    = 8,
    parameter int WARP_SIZE    = 32,
    parameter int PC_WIDTH     = 32,
    parameter int AGE_WIDTH    = 8,
    parameter int NUM_PC_PORTS = 2,
    localparam int WID         = $clog2(NUM_WARPS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            init_valid,
    input  logic [WID-1:0]                  init_warp_id,
    input  logic [PC_WIDTH-1:0]             init_pc,
    input  logic [WARP_SIZE-1:0]            init_mask,
    input  logic [NUM_PC_PORTS-1:0]         pc_update,
    input  logic [NUM_PC_PORTS*WID-1:0]     pc_warp_id,
    input  logic [NUM_PC_PORTS*PC_WIDTH-1:0] new_pc,
    input  logic                            mask_update,
    input  logic [WID-1:0]                  mask_warp_id,
    input  logic [WARP_SIZE-1:0]            new_mask,
    input  logic                            stall_set,
    input  logic                            stall_clr,
    input  logic [WID-1:0]                  stall_warp_id,
    input  logic                            bar_arrive,
    input  logic [WID-1:0]                  bar_warp_id,
    input  logic                            warp_issued,
    input  logic [WID-1:0]                  issued_warp_id,
    output logic [NUM_WARPS*PC_WIDTH-1:0]   pc_out,
    output logic [NUM_WARPS*WARP_SIZE-1:0]  mask_out,
    output logic [NUM_WARPS*3-1:0]          status_out,
    output logic [NUM_WARPS*AGE_WIDTH-1:0]  age_out,
    output logic [NUM_WARPS-1:0]            valid_out,
    output logic [WID:0]                    active_count,
    output logic                            all_done,
    output logic                            bar_release
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READY   = 3'd1,
        ST_STALLED = 3'd2,
        ST_BARRIER = 3'd3,
        ST_DONE    = 3'd4
    } status_t;

    logic [PC_WIDTH-1:0]  pc_q     [NUM_WARPS];
    logic [PC_WIDTH-1:0]  pc_d     [NUM_WARPS];
    logic [WARP_SIZE-1:0] mask_q   [NUM_WARPS];
    logic [WARP_SIZE-1:0] mask_d   [NUM_WARPS];
    status_t              status_q [NUM_WARPS];
    status_t              status_d [NUM_WARPS];
    logic [AGE_WIDTH-1:0] age_q    [NUM_WARPS];
    logic [AGE_WIDTH-1:0] age_d    [NUM_WARPS];
    logic [NUM_WARPS-1:0] valid_q;
    logic [NUM_WARPS-1:0] valid_d;
    logic [WID:0]         active_q;
    logic [WID:0]         active_d;
    logic [WID:0]         bar_cnt;
    logic                 release_now;
    logic                 any_valid;
    logic                 all_done_q;
    logic                 all_done_d;
    logic                 bar_release_q;

    // Release is judged on registered state, so a warp retiring this cycle
    // completes the barrier one cycle after it is seen as DONE.
    always_comb begin
        bar_cnt = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (status_q[w] == ST_BARRIER)
                bar_cnt = bar_cnt + (WID+1)'(1);
        end
        release_now = (bar_cnt != '0) && (bar_cnt == active_q);
    end

    // Later writes in this block take priority: age/stall/barrier, then
    // release, then mask (DONE), PC ports in ascending order, and init last.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            pc_d[w]     = pc_q[w];
            mask_d[w]   = mask_q[w];
            status_d[w] = status_q[w];
            age_d[w]    = age_q[w];
            valid_d[w]  = valid_q[w];

            if (valid_q[w] && status_q[w] == ST_READY && age_q[w] != {AGE_WIDTH{1'b1}})
                age_d[w] = age_q[w] + AGE_WIDTH'(1);
            if (warp_issued && issued_warp_id == WID'(w))
                age_d[w] = '0;

            if (stall_set && stall_warp_id == WID'(w) && status_q[w] == ST_READY)
                status_d[w] = ST_STALLED;
            if (stall_clr && stall_warp_id == WID'(w) && status_q[w] == ST_STALLED)
                status_d[w] = ST_READY;
            if (bar_arrive && bar_warp_id == WID'(w) && status_q[w] == ST_READY)
                status_d[w] = ST_BARRIER;

            if (release_now && status_q[w] == ST_BARRIER) begin
                status_d[w] = ST_READY;
                age_d[w]    = '0;
            end

            if (mask_update && mask_warp_id == WID'(w)) begin
                mask_d[w] = new_mask;
                if (new_mask == '0)
                    status_d[w] = ST_DONE;
            end

            for (int p = 0; p < NUM_PC_PORTS; p++) begin
                if (pc_update[p] && pc_warp_id[p*WID +: WID] == WID'(w))
                    pc_d[w] = new_pc[p*PC_WIDTH +: PC_WIDTH];
            end

            if (init_valid && init_warp_id == WID'(w)) begin
                pc_d[w]     = init_pc;
                mask_d[w]   = init_mask;
                status_d[w] = ST_READY;
                age_d[w]    = '0;
                valid_d[w]  = 1'b1;
            end
        end
    end

    always_comb begin
        active_d  = '0;
        any_valid = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (valid_d[w]) begin
                any_valid = 1'b1;
                if (status_d[w] != ST_DONE)
                    active_d = active_d + (WID+1)'(1);
            end
        end
        all_done_d = any_valid && (active_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]     <= '0;
                mask_q[w]   <= '0;
                status_q[w] <= ST_IDLE;
                age_q[w]    <= '0;
            end
            valid_q       <= '0;
            active_q      <= '0;
            all_done_q    <= 1'b0;
            bar_release_q <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]     <= pc_d[w];
                mask_q[w]   <= mask_d[w];
                status_q[w] <= status_d[w];
                age_q[w]    <= age_d[w];
            end
            valid_q       <= valid_d;
            active_q      <= active_d;
            all_done_q    <= all_done_d;
            bar_release_q <= release_now;
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            pc_out[w*PC_WIDTH +: PC_WIDTH]     = pc_q[w];
            mask_out[w*WARP_SIZE +: WARP_SIZE] = mask_q[w];
            status_out[w*3 +: 3]               = status_q[w];
            age_out[w*AGE_WIDTH +: AGE_WIDTH]  = age_q[w];
        end
    end

    assign valid_out    = valid_q;
    assign active_count = active_q;
    assign all_done     = all_done_q;
    assign bar_release  = bar_release_q;

endmodule

// File: tb/tb_warp_context_table.sv
// tb/tb_warp_context_table.sv - scoreboard bench for warp_context_table
// with directed vectors and a decoupled output monitor.
module tb_warp_context_table;

    localparam int NW  = 8;
    localparam int WS  = 32;
    localparam int PCW = 32;
    localparam int AW  = 2;
    localparam int NP  = 2;
    localparam int WID = 3;

    localparam int K_PC = 0, K_MASK = 1, K_ST = 2, K_AGE = 3, K_VAL = 4,
                   K_ACT = 5, K_DONE = 6, K_BAR = 7;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                init_valid;
    logic [WID-1:0]      init_warp_id;
    logic [PCW-1:0]      init_pc;
    logic [WS-1:0]       init_mask;
    logic [NP-1:0]       pc_update;
    logic [NP*WID-1:0]   pc_warp_id;
    logic [NP*PCW-1:0]   new_pc;
    logic                mask_update;
    logic [WID-1:0]      mask_warp_id;
    logic [WS-1:0]       new_mask;
    logic                stall_set;
    logic                stall_clr;
    logic [WID-1:0]      stall_warp_id;
    logic                bar_arrive;
    logic [WID-1:0]      bar_warp_id;
    logic                warp_issued;
    logic [WID-1:0]      issued_warp_id;
    logic [NW*PCW-1:0]   pc_out;
    logic [NW*WS-1:0]    mask_out;
    logic [NW*3-1:0]     status_out;
    logic [NW*AW-1:0]    age_out;
    logic [NW-1:0]       valid_out;
    logic [WID:0]        active_count;
    logic                all_done;
    logic                bar_release;

    warp_context_table #(
        .NUM_WARPS(NW), .WARP_SIZE(WS), .PC_WIDTH(PCW),
        .AGE_WIDTH(AW), .NUM_PC_PORTS(NP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .init_valid(init_valid), .init_warp_id(init_warp_id),
        .init_pc(init_pc), .init_mask(init_mask),
        .pc_update(pc_update), .pc_warp_id(pc_warp_id), .new_pc(new_pc),
        .mask_update(mask_update), .mask_warp_id(mask_warp_id), .new_mask(new_mask),
        .stall_set(stall_set), .stall_clr(stall_clr), .stall_warp_id(stall_warp_id),
        .bar_arrive(bar_arrive), .bar_warp_id(bar_warp_id),
        .warp_issued(warp_issued), .issued_warp_id(issued_warp_id),
        .pc_out(pc_out), .mask_out(mask_out), .status_out(status_out),
        .age_out(age_out), .valid_out(valid_out), .active_count(active_count),
        .all_done(all_done), .bar_release(bar_release)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       nm;
        int          kind;
        int          idx;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [63:0] actual(input int kind, input int idx);
        case (kind)
            K_PC:    return 64'(pc_out[idx*PCW +: PCW]);
            K_MASK:  return 64'(mask_out[idx*WS +: WS]);
            K_ST:    return 64'(status_out[idx*3 +: 3]);
            K_AGE:   return 64'(age_out[idx*AW +: AW]);
            K_VAL:   return 64'(valid_out[idx]);
            K_ACT:   return 64'(active_count);
            K_DONE:  return 64'(all_done);
            default: return 64'(bar_release);
        endcase
    endfunction

    // Expectations describe the registered outputs after the coming posedge.
    task automatic exp(input string nm, input int kind, input int idx, input logic [63:0] v);
        exp_t e;
        e.cyc = cyc + 1;
        e.nm = nm;
        e.kind = kind;
        e.idx = idx;
        e.val = v;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                logic [63:0] a;
                e = sb.pop_front();
                a = actual(e.kind, e.idx);
                total++;
                if (a !== e.val) begin
                    bad++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", e.nm, a, e.val);
                end
            end
        end
    end

    task automatic clr();
        init_valid = 0; init_warp_id = '0; init_pc = '0; init_mask = '0;
        pc_update = '0; pc_warp_id = '0; new_pc = '0;
        mask_update = 0; mask_warp_id = '0; new_mask = '0;
        stall_set = 0; stall_clr = 0; stall_warp_id = '0;
        bar_arrive = 0; bar_warp_id = '0;
        warp_issued = 0; issued_warp_id = '0;
    endtask

    task automatic step();
        @(negedge clk);
        clr();
    endtask

    task automatic do_init(input int w, input logic [31:0] pc, input logic [31:0] m);
        init_valid = 1; init_warp_id = WID'(w); init_pc = pc; init_mask = m;
    endtask

    task automatic do_mask(input int w, input logic [31:0] m);
        mask_update = 1; mask_warp_id = WID'(w); new_mask = m;
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    initial begin
        clr();
        rst_n = 0;
        @(negedge clk);
        exp("rst_status0", K_ST, 0, 0);
        exp("rst_valid", K_VAL, 2, 0);
        exp("rst_active", K_ACT, 0, 0);
        exp("rst_all_done", K_DONE, 0, 0);
        exp("rst_bar_release", K_BAR, 0, 0);
        exp("rst_pc2", K_PC, 2, 0);
        step();
        rst_n = 1;

        // Launch and multi-port PC writeback
        do_init(2, 32'h100, 32'hFFFF_FFFF);
        exp("init_status2", K_ST, 2, 1);
        exp("init_valid2", K_VAL, 2, 1);
        exp("init_pc2", K_PC, 2, 32'h100);
        exp("init_active", K_ACT, 0, 1);
        exp("init_all_done", K_DONE, 0, 0);
        step();
        pc_update = 2'b11; pc_warp_id = {3'd3, 3'd3}; new_pc = {32'h80, 32'h40};
        exp("pc_collide_w3", K_PC, 3, 32'h80);
        step();
        pc_update = 2'b11; pc_warp_id = {3'd4, 3'd1}; new_pc = {32'h20, 32'h10};
        exp("pc_port0_w1", K_PC, 1, 32'h10);
        exp("pc_port1_w4", K_PC, 4, 32'h20);
        exp("pc_idle_w4_status", K_ST, 4, 0);
        step();

        // Saturating age with AGE_WIDTH=2
        do_reset();
        do_init(0, 0, 1);
        step();
        do_init(1, 0, 1); warp_issued = 1; issued_warp_id = 0;
        step();
        do_init(2, 0, 1); warp_issued = 1; issued_warp_id = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            warp_issued = 1; issued_warp_id = 0;
            if (i == 0) begin
                exp("age_w1_first", K_AGE, 1, 2);
                exp("age_w2_first", K_AGE, 2, 1);
            end
            if (i == 4) begin
                exp("age_w0_sat", K_AGE, 0, 0);
                exp("age_w1_sat", K_AGE, 1, 3);
                exp("age_w2_sat", K_AGE, 2, 3);
                exp("age_active", K_ACT, 0, 3);
            end
            step();
        end

        // Barrier completed by a retiring warp
        do_reset();
        for (int w = 0; w < 4; w++) begin
            do_init(w, 32'(w), 32'hF);
            step();
        end
        for (int w = 0; w < 3; w++) begin
            bar_arrive = 1; bar_warp_id = WID'(w);
            exp($sformatf("bar_status%0d", w), K_ST, w, 3);
            exp($sformatf("bar_norelease%0d", w), K_BAR, 0, 0);
            step();
        end
        do_mask(3, 0);
        stall_set = 1; stall_warp_id = 0;
        exp("done_status3", K_ST, 3, 4);
        exp("stall_on_barrier", K_ST, 0, 3);
        exp("done_active", K_ACT, 0, 3);
        exp("done_bar_release", K_BAR, 0, 0);
        step();
        exp("release_pulse", K_BAR, 0, 1);
        exp("release_st0", K_ST, 0, 1);
        exp("release_st1", K_ST, 1, 1);
        exp("release_st2", K_ST, 2, 1);
        exp("release_age0", K_AGE, 0, 0);
        step();
        exp("release_once", K_BAR, 0, 0);
        exp("post_release_age1", K_AGE, 1, 1);
        step();

        // init beats mask=0 on the same warp
        do_init(5, 32'h55, 32'hABCD);
        do_mask(5, 0);
        exp("init_beats_mask_st", K_ST, 5, 1);
        exp("init_beats_mask_m", K_MASK, 5, 32'hABCD);
        exp("init_beats_mask_act", K_ACT, 0, 4);
        step();

        // Retire everything
        for (int w = 0; w < 3; w++) begin
            do_mask(w, 0);
            if (w == 2) begin
                exp("partial_active", K_ACT, 0, 1);
                exp("partial_all_done", K_DONE, 0, 0);
            end
            step();
        end
        do_mask(5, 0);
        exp("all_done", K_DONE, 0, 1);
        exp("all_active", K_ACT, 0, 0);
        exp("all_mask5", K_MASK, 5, 0);
        step();

        // Reset while a barrier release is pending
        do_reset();
        do_init(1, 32'h77, 32'h1);
        step();
        bar_arrive = 1; bar_warp_id = 1;
        exp("pend_bar_st1", K_ST, 1, 3);
        exp("pend_bar_active", K_ACT, 0, 1);
        step();
        #1 rst_n = 0;
        exp("midrst_bar", K_BAR, 0, 0);
        exp("midrst_st1", K_ST, 1, 0);
        exp("midrst_valid", K_VAL, 1, 0);
        exp("midrst_pc1", K_PC, 1, 0);
        exp("midrst_active", K_ACT, 0, 0);
        step();
        rst_n = 1;
        exp("postrst_bar", K_BAR, 0, 0);
        exp("postrst_all_done", K_DONE, 0, 0);
        step();
        step();

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
